// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding, converter bus widths and round-robin helper for the ADC scan arbiter.
package adc_pkg;
    localparam int IDX_W  = 3;
    localparam int CH_W   = 3;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        START,
        WAIT_LO,
        WAIT_HI,
        READ
    } adc_state_e;

    function automatic int rr_wrap(input int a, input int n);
        return (a >= n) ? a - n : a;
    endfunction
endpackage

// File: rtl/adc_rr_arbiter.sv
// adc_rr_arbiter: combinational round-robin pick, searching upward from ptr with wraparound.
module adc_rr_arbiter
    import adc_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);
    int j;
    // Walk offsets from far to near so the closest requester after ptr wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = rr_wrap(int'(ptr) + k, N_REQ);
            if (|(req & (N_REQ'(1) << j))) begin
                gnt = N_REQ'(1) << j;
                idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/adc_scan_arbiter.sv
// adc_scan_arbiter: round-robin scanner sharing one ADC0808-style converter among N_REQ requesters.
// Define ADC_TIMEOUT_EN to abandon conversions whose EOC handshake stalls for TIMEOUT_TICKS ticks.
module adc_scan_arbiter
    import adc_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int TICK_DIV      = 6250,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req,
    input  logic [3*N_REQ-1:0]  req_ch,
    output logic [N_REQ-1:0]    grant,
    output logic                data_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic [IDX_W-1:0]    data_id,
    output logic [CH_W-1:0]     adc_addr,
    output logic                ale,
    output logic                start,
    output logic                oe,
    input  logic                eoc,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                busy,
    output logic                timeout_err
);
    localparam int DIV_W = $clog2(TICK_DIV + 1);

    adc_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;
    logic              eoc_meta_q, eoc_sync_q;
    logic [IDX_W-1:0]  ptr_q, ptr_d, id_q, id_d, data_id_q, data_id_d, win_idx, ptr_nxt;
    logic [N_REQ-1:0]  sel_q, sel_d, grant_q, grant_d, win_gnt;
    logic [CH_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    adc_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign tick    = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d   = tick ? '0 : div_q + 1'b1;
    assign ptr_nxt = IDX_W'(rr_wrap(int'(id_q) + 1, N_REQ));

`ifdef ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q, to_err_d;
    logic            to_hit;
    assign to_hit      = (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1));
    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        data_id_d = data_id_q;
        grant_d   = '0;
        valid_d   = 1'b0;
`ifdef ADC_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        to_err_d  = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                IDLE: if (|req) begin
                    id_d    = win_idx;
                    sel_d   = win_gnt;
                    addr_d  = CH_W'(req_ch >> (CH_W * int'(win_idx)));
                    state_d = ADDR;
                end
                ADDR:    state_d = START;
                START:   state_d = WAIT_LO;
                WAIT_LO: if (!eoc_sync_q) state_d = WAIT_HI;
                WAIT_HI: if (eoc_sync_q) state_d = READ;
                READ: begin
                    data_d    = adc_data;
                    data_id_d = id_q;
                    grant_d   = sel_q;
                    valid_d   = 1'b1;
                    ptr_d     = ptr_nxt;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
`ifdef ADC_TIMEOUT_EN
            // The tick budget restarts in each wait state; a stall skips the requester.
            if (state_q == WAIT_LO || state_q == WAIT_HI) begin
                if (state_d != state_q) begin
                    to_cnt_d = '0;
                end else if (to_hit) begin
                    to_cnt_d = '0;
                    to_err_d = 1'b1;
                    ptr_d    = ptr_nxt;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            div_q      <= '0;
            eoc_meta_q <= 1'b0;
            eoc_sync_q <= 1'b0;
            ptr_q      <= '0;
            id_q       <= '0;
            sel_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            data_id_q  <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            eoc_meta_q <= eoc;
            eoc_sync_q <= eoc_meta_q;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            data_id_q  <= data_id_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
        end
    end

`ifdef ADC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end
`endif

    assign grant      = grant_q;
    assign data_valid = valid_q;
    assign data_out   = data_q;
    assign data_id    = data_id_q;
    assign adc_addr   = addr_q;
    assign ale        = (state_q == ADDR);
    assign start      = (state_q == START);
    assign oe         = (state_q == READ);
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_adc_scan_arbiter.sv
// tb_adc_scan_arbiter: scoreboard bench with a behavioural ADC0808-style converter model.
`timescale 1ns/1ps
module tb_adc_scan_arbiter;
    localparam int TD = 4;
    localparam int TO = 8;

    typedef struct {
        logic [2:0] id;
        logic [2:0] ch;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [11:0] req_ch;
    logic [3:0]  grant;
    logic        data_valid;
    logic [7:0]  data_out;
    logic [2:0]  data_id;
    logic [2:0]  adc_addr;
    logic        ale, start, oe, eoc, busy, timeout_err;
    logic [7:0]  adc_data;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ale_n = 0, start_n = 0, oe_n = 0, t_ale = 0;
    logic ale_p = 1'b0, start_p = 1'b0;
    logic [2:0] a_lat = '0;
    logic conv_busy = 1'b0;
    logic stuck = 1'b0;
    time  t0;

    adc_scan_arbiter #(.N_REQ(4), .TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .req_ch      (req_ch),
        .grant       (grant),
        .data_valid  (data_valid),
        .data_out    (data_out),
        .data_id     (data_id),
        .adc_addr    (adc_addr),
        .ale         (ale),
        .start       (start),
        .oe          (oe),
        .eoc         (eoc),
        .adc_data    (adc_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {8'd0, grant, data_valid, data_out, data_id, adc_addr, ale, start, oe, busy, timeout_err};
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Converter: eoc falls two ticks after start, stays low three ticks, result appears with the rise.
    initial begin
        eoc = 1'b1;
        adc_data = 8'h00;
        forever begin
            @(negedge clk iff (start && !stuck));
            conv_busy = 1'b1;
            if (exp_q.size() != 0) check("conv_addr", adc_addr, exp_q[0].ch);
            repeat (2 * TD) @(negedge clk);
            eoc = 1'b0;
            repeat (3 * TD) @(negedge clk);
            adc_data = (exp_q.size() != 0) ? exp_q[0].data : 8'h00;
            eoc = 1'b1;
            conv_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (data_valid) begin
            if (exp_q.size() == 0) check("unexp_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("data_id", data_id, e.id);
                check("data_out", data_out, e.data);
                check("grant", grant, 4'b0001 << e.id);
            end
        end else if (grant != 4'b0000) check("grant_no_valid", grant, 0);
        if (ale) ale_n++; else if (ale_n != 0) begin check("ale_width", ale_n, TD); ale_n = 0; end
        if (start) start_n++; else if (start_n != 0) begin check("start_width", start_n, TD); start_n = 0; end
        if (oe) oe_n++; else if (oe_n != 0) begin check("oe_width", oe_n, TD); oe_n = 0; end
        if (ale && !ale_p) begin t_ale = cyc; a_lat = adc_addr; end
        if (start && !start_p) check("ale_to_start", cyc - t_ale, TD);
        if (busy) check("addr_stable", adc_addr, a_lat);
        ale_p = ale;
        start_p = start;
    end

    initial begin
        rstn = 1'b0;
        req = 4'b0000;
        req_ch = {3'd6, 3'd5, 3'd4, 3'd3};
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        rstn = 1'b1;

        // Single requester 2 on channel 5.
        exp_q.push_back('{3'd2, 3'd5, 8'hA5});
        req = 4'b0100;
        wait_done("single_req2", 400);
        req = 4'b0000;

        // Reset during WAIT_LO must clear everything immediately and reset the pointer.
        req = 4'b1000;
        for (int n = 0; n < 100 && !start; n++) begin @(negedge clk); #1; end
        check("rst_start_seen", start, 1);
        for (int n = 0; n < 100 && start; n++) begin @(negedge clk); #1; end
        check("rst_in_wait_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 0);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 200 && conv_busy; n++) begin @(negedge clk); #1; end
        check("conv_idle", conv_busy, 0);

        // All requesting: round robin from index 0.
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{3'(k % 4), 3'((k % 4) + 3), 8'(8'h10 + k)});
        req = 4'b1111;
        wait_done("rr_all", 1500);
        req = 4'b0000;

        // Requester 1 drops during WAIT_HI; result still delivered.
        exp_q.push_back('{3'd1, 3'd4, 8'h3C});
        req = 4'b0010;
        for (int n = 0; n < 200 && eoc; n++) begin @(negedge clk); #1; end
        check("drop_eoc_low", eoc, 0);
        repeat (2 * TD) @(negedge clk);
        #1;
        check("drop_busy", busy, 1);
        req = 4'b0000;
        wait_done("drop_req1", 400);

        repeat (10 * TD) @(negedge clk);
        #1;
        check("quiet_busy", busy, 0);
        check("quiet_queue", exp_q.size(), 0);

`ifdef ADC_TIMEOUT_EN
        stuck = 1'b1;
        req = 4'b0001;
        for (int n = 0; n < 100 && !start; n++) begin @(negedge clk); #1; end
        check("to_start_seen", start, 1);
        for (int n = 0; n < 100 && start; n++) begin @(negedge clk); #1; end
        t0 = $time;
        for (int n = 0; n < 20 * TD && !timeout_err; n++) begin @(negedge clk); #1; end
        check("to_seen", timeout_err, 1);
        check("to_latency", int'(($time - t0) / 10), TO * TD);
        check("to_busy", busy, 0);
        req = 4'b0000;
        stuck = 1'b0;
        exp_q.push_back('{3'd1, 3'd4, 8'h5A});
        req = 4'b0011;
        wait_done("to_rr_advance", 400);
        req = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
